// File: rtl/alu_1_issue.sv
// alu_1_issue: issues one PHV container op to an external ALU and writes the result back.
// One op in flight; IDLE -> ISSUE -> WAIT -> OUT, or IDLE -> OUT for bypassed actions.
module alu_1_issue #(
    parameter int STAGE      = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int NUM_CONT   = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
    input  logic [ACTION_LEN-1:0]          action_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [ACTION_LEN-1:0]          alu_action,
    output logic                           alu_action_valid,
    output logic [DATA_WIDTH-1:0]          alu_operand_1,
    output logic [DATA_WIDTH-1:0]          alu_operand_2,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    input  logic                           alu_result_valid,
    output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
    output logic                           phv_out_valid,
    input  logic                           phv_out_ready,
    output logic                           err_timeout
);
    localparam int PHV_W = NUM_CONT * DATA_WIDTH;
    localparam int IDX_W = (NUM_CONT > 1) ? $clog2(NUM_CONT) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_t;
    state_t r_state, w_state_next;

    logic                  r_in_ready, r_action_valid, r_out_valid, r_err;
    logic [ACTION_LEN-1:0] r_action;
    logic [DATA_WIDTH-1:0] r_op1, r_op2;
    logic [PHV_W-1:0]      r_phv;
    logic [IDX_W-1:0]      r_dest;
    logic [CNT_W-1:0]      r_cnt;

    logic [3:0]            w_opcode;
    logic [4:0]            w_idx1, w_idx2;
    logic                  w_is_reg, w_is_imm, w_bypass, w_accept, w_take, w_expire;
    logic [DATA_WIDTH-1:0] w_op1_sel, w_op2_reg, w_op2_sel;
    logic                  w_unused_stage;

    assign w_unused_stage = ^STAGE;

    assign w_opcode = action_in[24:21];
    assign w_idx1   = action_in[20:16];
    assign w_idx2   = action_in[15:11];
    assign w_is_reg = (w_opcode == 4'b0001) || (w_opcode == 4'b0010);
    assign w_is_imm = (w_opcode == 4'b1001) || (w_opcode == 4'b1010);
    assign w_bypass = !(w_is_reg || w_is_imm) || (int'(w_idx1) >= NUM_CONT) ||
                      (w_is_reg && (int'(w_idx2) >= NUM_CONT));
    assign w_accept = in_valid && (r_state == StIdle);

    always_comb begin
        w_op1_sel = '0;
        w_op2_reg = '0;
        for (int k = 0; k < NUM_CONT; k++) begin
            if (int'(w_idx1) == k) w_op1_sel = phv_in[k*DATA_WIDTH +: DATA_WIDTH];
            if (int'(w_idx2) == k) w_op2_reg = phv_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
        w_op2_sel = w_is_imm ? {{(DATA_WIDTH-16){1'b0}}, action_in[15:0]} : w_op2_reg;
    end

    // A result on the expiry cycle takes priority over the timeout.
    assign w_take   = (r_state == StWait) && alu_result_valid;
    assign w_expire = (r_state == StWait) && !alu_result_valid && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = w_bypass ? StOut : StIssue;
            StIssue: w_state_next = StWait;
            StWait:  if (w_take || w_expire) w_state_next = StOut;
            StOut:   if (phv_out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b1;
            r_action_valid <= 1'b0;
            r_out_valid    <= 1'b0;
            r_err          <= 1'b0;
            r_action       <= '0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_phv          <= '0;
            r_dest         <= '0;
            r_cnt          <= '0;
        end else begin
            r_in_ready     <= (w_state_next == StIdle);
            r_action_valid <= (w_state_next == StIssue);
            r_out_valid    <= (w_state_next == StOut);
            if (w_accept) begin
                r_phv    <= phv_in;
                r_action <= action_in;
                r_op1    <= w_op1_sel;
                r_op2    <= w_op2_sel;
                r_dest   <= w_idx1[IDX_W-1:0];
            end
            if (r_state == StIssue) begin
                r_cnt <= '0;
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_take) begin
                for (int k = 0; k < NUM_CONT; k++) begin
                    if (r_dest == IDX_W'(k)) r_phv[k*DATA_WIDTH +: DATA_WIDTH] <= alu_result;
                end
            end
            if (w_expire) r_err <= 1'b1;
        end
    end

    assign in_ready         = r_in_ready;
    assign alu_action       = r_action;
    assign alu_action_valid = r_action_valid;
    assign alu_operand_1    = r_op1;
    assign alu_operand_2    = r_op2;
    assign phv_out          = r_phv;
    assign phv_out_valid    = r_out_valid;
    assign err_timeout      = r_err;

endmodule

// File: tb/tb_alu_1_issue.sv
// Testbench for alu_1_issue: stub ALU with programmable latency, random backpressure and a
// scoreboard of expected PHVs produced by a container-level reference model.
module tb_alu_1_issue;
    localparam int DW = 48;
    localparam int NC = 8;
    localparam int AL = 25;
    localparam int TO = 16;
    localparam int PW = NC * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] phv_in = '0;
    logic [AL-1:0] action_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AL-1:0] alu_action;
    logic          alu_action_valid;
    logic [DW-1:0] alu_operand_1, alu_operand_2;
    logic [DW-1:0] alu_result;
    logic          alu_result_valid;
    logic [PW-1:0] phv_out;
    logic          phv_out_valid;
    logic          phv_out_ready;
    logic          err_timeout;

    always #5 clk = ~clk;

    alu_1_issue #(
        .STAGE(0), .ACTION_LEN(AL), .DATA_WIDTH(DW), .NUM_CONT(NC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .phv_in(phv_in), .action_in(action_in),
        .in_valid(in_valid), .in_ready(in_ready), .alu_action(alu_action),
        .alu_action_valid(alu_action_valid), .alu_operand_1(alu_operand_1),
        .alu_operand_2(alu_operand_2), .alu_result(alu_result),
        .alu_result_valid(alu_result_valid), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
        .phv_out_ready(phv_out_ready), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [PW-1:0] phv;
        bit            err;
        int            lat;
    } sb_t;
    typedef struct {
        logic [AL-1:0] act;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        int            lat;
    } op_t;

    sb_t sb_q[$];
    op_t op_q[$];
    int  acc_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  err_model = 1'b0;
    int  bp_hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic abort(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Container-level reference: which container changes, and to what, for a given action.
    function automatic void model(input logic [PW-1:0] phv, input logic [AL-1:0] act,
                                  input int lat, output logic [PW-1:0] exp, output bit byp,
                                  output bit tout, output logic [DW-1:0] op1,
                                  output logic [DW-1:0] op2);
        logic [DW-1:0] c[NC];
        int opc, i1, i2;
        bit reg_form, imm_form;
        opc = int'(act[24:21]);
        i1 = int'(act[20:16]);
        i2 = int'(act[15:11]);
        reg_form = (opc == 1) || (opc == 2);
        imm_form = (opc == 9) || (opc == 10);
        for (int k = 0; k < NC; k++) c[k] = phv[k*DW +: DW];
        byp = !(reg_form || imm_form) || (i1 >= NC) || (reg_form && i2 >= NC);
        tout = 1'b0;
        op1 = '0;
        op2 = '0;
        if (!byp) begin
            op1 = c[i1];
            op2 = imm_form ? DW'(act[15:0]) : c[i2];
            if (lat >= 1 && lat <= TO) c[i1] = (opc == 2 || opc == 10) ? op1 - op2 : op1 + op2;
            else tout = 1'b1;
        end
        for (int k = 0; k < NC; k++) exp[k*DW +: DW] = c[k];
    endfunction

    function automatic logic [PW-1:0] rand_phv();
        logic [PW-1:0] p;
        for (int k = 0; k < NC; k++) p[k*DW +: DW] = DW'({$urandom(), $urandom()});
        return p;
    endfunction

    // Called on a negedge; returns on the negedge after the accepting clock edge.
    task automatic issue(input logic [PW-1:0] phv, input logic [AL-1:0] act, input int lat,
                         input int hold);
        logic [PW-1:0] exp;
        bit byp, tout;
        logic [DW-1:0] o1, o2;
        int n;
        model(phv, act, lat, exp, byp, tout, o1, o2);
        if (!byp && tout) err_model = 1'b1;
        sb_q.push_back('{exp, err_model, byp ? 1 : (tout ? TO + 2 : lat + 2)});
        if (!byp) op_q.push_back('{act, o1, o2, lat});
        if (hold > 0) bp_hold = hold;
        phv_in = phv;
        action_in = act;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) abort("accept_wait");
        end
        acc_q.push_back(cyc);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            n++;
            if (n > 300) abort("drain_wait");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : alu_stub
        int  cd;
        op_t o;
        cd = 0;
        alu_result_valid = 1'b0;
        alu_result = '0;
        forever begin
            @(negedge clk);
            alu_result_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) alu_result_valid = 1'b1;
            end
            if (alu_action_valid) begin
                if (op_q.size() == 0) begin
                    check("unexpected_alu_pulse", PW'(alu_action_valid), '0);
                end else begin
                    o = op_q.pop_front();
                    check("alu_action", PW'(alu_action), PW'(o.act));
                    check("alu_operand_1", PW'(alu_operand_1), PW'(o.op1));
                    check("alu_operand_2", PW'(alu_operand_2), PW'(o.op2));
                    cd = o.lat;
                    if (alu_action[24:21] == 4'd2 || alu_action[24:21] == 4'd10)
                        alu_result = alu_operand_1 - alu_operand_2;
                    else
                        alu_result = alu_operand_1 + alu_operand_2;
                end
            end
        end
    end

    initial begin : ready_gen
        phv_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bp_hold > 0) begin
                phv_out_ready = 1'b0;
                if (phv_out_valid) bp_hold--;
            end else begin
                phv_out_ready = ($urandom_range(3) != 0);
            end
        end
    end

    initial begin : monitor
        bit            pv, pr;
        logic [PW-1:0] held;
        sb_t           e;
        int            a;
        pv = 1'b0;
        pr = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b0;
                continue;
            end
            if (pv && !pr) begin
                check("out_valid_held", PW'(phv_out_valid), PW'(1));
                check("out_data_held", phv_out, held);
                check("in_ready_while_out", PW'(in_ready), '0);
            end else if (phv_out_valid) begin
                if (sb_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_output", PW'(phv_out_valid), '0);
                end else begin
                    e = sb_q.pop_front();
                    a = acc_q.pop_front();
                    check("phv_out", phv_out, e.phv);
                    check("err_timeout", PW'(err_timeout), PW'(e.err));
                    check("latency", PW'(cyc - a), PW'(e.lat));
                    check("in_ready_while_out", PW'(in_ready), '0);
                end
                held = phv_out;
            end
            pv = phv_out_valid;
            pr = phv_out_ready;
        end
    end

    initial begin : watchdog
        #500000;
        abort("global_timeout");
    end

    initial begin : main
        logic [PW-1:0] p;
        logic [3:0]    opc;
        logic [4:0]    i1, i2;
        int            sel, lat;

        repeat (2) @(negedge clk);
        check("rst_in_ready", PW'(in_ready), PW'(1));
        check("rst_alu_valid", PW'(alu_action_valid), '0);
        check("rst_out_valid", PW'(phv_out_valid), '0);
        check("rst_err", PW'(err_timeout), '0);
        check("rst_phv_out", phv_out, '0);
        rst_n = 1'b1;
        @(negedge clk);

        p = rand_phv();
        p[2*DW +: DW] = DW'(100);
        p[5*DW +: DW] = DW'(23);
        issue(p, {4'b0001, 5'd2, 5'd5, 11'd0}, 3, 0);
        p = rand_phv();
        p[0 +: DW] = DW'(1);
        issue(p, {4'b1010, 5'd0, 16'd3}, 3, 0);
        issue(rand_phv(), {4'b0000, 5'd1, 5'd2, 11'd0}, 3, 0);
        issue(rand_phv(), {4'b0001, 5'd9, 5'd2, 11'd0}, 3, 0);
        issue(rand_phv(), {4'b0010, 5'd4, 5'd7, 11'd0}, TO, 0);
        issue(rand_phv(), {4'b1001, 5'd6, 16'h1234}, TO + 1, 0);
        issue(rand_phv(), {4'b0001, 5'd3, 5'd3, 11'd0}, 0, 0);
        drain();

        // Reset while the op sits in WAIT; its result shows up after reset is released.
        issue(rand_phv(), {4'b0001, 5'd1, 5'd3, 11'd0}, 8, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("wrst_in_ready", PW'(in_ready), PW'(1));
        check("wrst_alu_valid", PW'(alu_action_valid), '0);
        check("wrst_out_valid", PW'(phv_out_valid), '0);
        check("wrst_err", PW'(err_timeout), '0);
        check("wrst_phv_out", phv_out, '0);
        check("wrst_operand_1", PW'(alu_operand_1), '0);
        check("wrst_operand_2", PW'(alu_operand_2), '0);
        check("wrst_action", PW'(alu_action), '0);
        sb_q.delete();
        acc_q.delete();
        op_q.delete();
        err_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Backpressure for 10 cycles with a second op queued right behind.
        issue(rand_phv(), {4'b0001, 5'd0, 5'd7, 11'd0}, 3, 10);
        issue(rand_phv(), {4'b1001, 5'd7, 16'hffff}, 3, 0);
        drain();

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(5);
            case (sel)
                0: opc = 4'd1;
                1: opc = 4'd2;
                2: opc = 4'd9;
                3: opc = 4'd10;
                4: opc = 4'd0;
                default: opc = 4'($urandom());
            endcase
            i1 = 5'($urandom_range(9));
            i2 = 5'($urandom_range(9));
            lat = ($urandom_range(9) == 0) ? 0 : $urandom_range(6, 1);
            issue(rand_phv(), {opc, i1, i2, 11'($urandom())}, lat,
                  ($urandom_range(7) == 0) ? $urandom_range(5, 1) : 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
